// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bundle between the control sequencer and the ALU datapath system.
// Ports (master = sequencer view):
//   in  IROut[15:0], FlagsOut[3:0] (bit3 = Z)
//   out RF_OutASel/RF_OutBSel/RF_FunSel[2:0], RF_RegSel/RF_ScrSel[3:0], ALU_FunSel[4:0], ALU_WF,
//       ARF_OutCSel/ARF_OutDSel[1:0], ARF_FunSel/ARF_RegSel[2:0], IR_LH, IR_Write, Mem_WR, Mem_CS (low active),
//       MuxASel/MuxBSel[1:0], MuxCSel, SeqState[2:0], Halted, Illegal (only with CU_ILLEGAL_TRAP_EN)
interface control_sequencer_if;
    logic [15:0] IROut;
    logic [3:0]  FlagsOut;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [2:0]  SeqState;
    logic        Halted;
`ifdef CU_ILLEGAL_TRAP_EN
    logic        Illegal;
`endif
    modport master (
        input  IROut, FlagsOut,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, SeqState, Halted
`ifdef CU_ILLEGAL_TRAP_EN
        , Illegal
`endif
    );
    modport slave (
        output IROut, FlagsOut,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, SeqState, Halted
`ifdef CU_ILLEGAL_TRAP_EN
        , Illegal
`endif
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired multi-cycle control unit (fetch two bytes, decode, execute) for the ALU datapath.
// Ports: Clock (rising edge), Reset (synchronous, active-high), bus (control_sequencer_if.master: IROut and
//   FlagsOut in, every datapath control plus SeqState/Halted out).
// Optional macro CU_ILLEGAL_TRAP_EN: undefined opcodes halt and raise a sticky bus.Illegal; otherwise they are NOPs.
module control_sequencer #(
    parameter logic [2:0] RF_FS_LOAD = 3'b010,
    parameter logic [2:0] RF_FS_INC  = 3'b001,
    parameter logic [4:0] ALU_PASSA  = 5'b10000,
    parameter logic [4:0] ALU_ADD    = 5'b10100
) (
    input logic Clock,
    input logic Reset,
    control_sequencer_if.master bus
);
    typedef enum logic [2:0] {FETCH_L = 3'd0, FETCH_H = 3'd1, EXEC = 3'd2, EXEC2 = 3'd3, HALT = 3'd4} state_t;
    state_t state, nextState;
    logic [5:0] opcode;
    assign opcode = bus.IROut[15:10];
    always_ff @(posedge Clock) state <= Reset ? FETCH_L : nextState;
`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal;
    // Only an undefined opcode reaches HALT from EXEC other than the explicit HALT opcode.
    always_ff @(posedge Clock)
        illegal <= Reset ? 1'b0 : (illegal | (state == EXEC && nextState == HALT && opcode != 6'h3F));
    assign bus.Illegal = illegal & ~Reset;
`endif
    always_comb begin
        bus.RF_OutASel  = '0;
        bus.RF_OutBSel  = '0;
        bus.RF_FunSel   = '0;
        bus.RF_RegSel   = '0;
        bus.RF_ScrSel   = '0;
        bus.ALU_FunSel  = '0;
        bus.ALU_WF      = 1'b0;
        bus.ARF_OutCSel = '0;
        bus.ARF_OutDSel = '0;
        bus.ARF_FunSel  = '0;
        bus.ARF_RegSel  = '0;
        bus.IR_LH       = 1'b0;
        bus.IR_Write    = 1'b0;
        bus.Mem_WR      = 1'b0;
        bus.Mem_CS      = 1'b1;
        bus.MuxASel     = '0;
        bus.MuxBSel     = '0;
        bus.MuxCSel     = 1'b0;
        bus.SeqState    = Reset ? 3'd0 : state;
        bus.Halted      = 1'b0;
        nextState       = state;
        if (!Reset) begin
            case (state)
                FETCH_L, FETCH_H: begin
                    bus.Mem_CS     = 1'b0;
                    bus.IR_Write   = 1'b1;
                    bus.IR_LH      = (state == FETCH_H);
                    bus.ARF_RegSel = 3'b100;
                    bus.ARF_FunSel = RF_FS_INC;
                    nextState      = (state == FETCH_L) ? FETCH_H : EXEC;
                end
                EXEC: begin
                    nextState = FETCH_L;
                    case (opcode)
                        6'h00, 6'h01: begin
                            // BRA always, BNE only when Z is clear; the branch target enters via MuxB.
                            if (opcode == 6'h00 || !bus.FlagsOut[3]) begin
                                bus.MuxBSel    = 2'd3;
                                bus.ARF_RegSel = 3'b100;
                                bus.ARF_FunSel = RF_FS_LOAD;
                            end
                        end
                        6'h02: begin
                            bus.MuxASel   = 2'd3;
                            bus.RF_FunSel = RF_FS_LOAD;
                            bus.RF_RegSel = 4'b1000 >> bus.IROut[9:8];
                        end
                        6'h03: begin
                            bus.RF_OutASel = {1'b0, bus.IROut[3:2]};
                            bus.RF_OutBSel = {1'b0, bus.IROut[1:0]};
                            bus.ALU_FunSel = ALU_ADD;
                            bus.ALU_WF     = bus.IROut[9];
                            bus.RF_FunSel  = RF_FS_LOAD;
                            bus.RF_RegSel  = 4'b1000 >> bus.IROut[5:4];
                        end
                        6'h04: begin
                            bus.RF_FunSel = RF_FS_INC;
                            bus.RF_RegSel = 4'b1000 >> bus.IROut[5:4];
                        end
                        6'h05: begin
                            bus.MuxBSel    = 2'd3;
                            bus.ARF_RegSel = 3'b010;
                            bus.ARF_FunSel = RF_FS_LOAD;
                            nextState      = EXEC2;
                        end
                        6'h3F: nextState = HALT;
                        default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                            nextState = HALT;
`endif
                        end
                    endcase
                end
                EXEC2: begin
                    // ST write phase: register passes through the ALU to memory at address AR.
                    bus.RF_OutASel  = {1'b0, bus.IROut[9:8]};
                    bus.ALU_FunSel  = ALU_PASSA;
                    bus.ARF_OutDSel = 2'd2;
                    bus.Mem_CS      = 1'b0;
                    bus.Mem_WR      = 1'b1;
                    nextState       = FETCH_L;
                end
                HALT: bus.Halted = 1'b1;
                default: nextState = FETCH_L;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed self-checking bench for control_sequencer.
module tb_control_sequencer;
    typedef struct packed {
        logic [2:0] outA, outB, rfFun;
        logic [3:0] regSel, scrSel;
        logic [4:0] aluFun;
        logic       aluWf;
        logic [1:0] outC, outD;
        logic [2:0] arfFun, arfReg;
        logic       irLh, irWrite, memWr, memCs;
        logic [1:0] muxA, muxB;
        logic       muxC;
        logic [2:0] seqState;
        logic       halted;
    } ctl_t;

    logic Clock, Reset;
    int nChecks = 0, nFail = 0;
    control_sequencer_if bus();
    ctl_t act, exp;

    control_sequencer dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    assign act = {bus.RF_OutASel, bus.RF_OutBSel, bus.RF_FunSel, bus.RF_RegSel, bus.RF_ScrSel, bus.ALU_FunSel,
                  bus.ALU_WF, bus.ARF_OutCSel, bus.ARF_OutDSel, bus.ARF_FunSel, bus.ARF_RegSel, bus.IR_LH,
                  bus.IR_Write, bus.Mem_WR, bus.Mem_CS, bus.MuxASel, bus.MuxBSel, bus.MuxCSel, bus.SeqState,
                  bus.Halted};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic ctl_t idleCtl();
        ctl_t c = '0;
        c.memCs = 1'b1;
        return c;
    endfunction

    // Expected outputs for step 0/1 (fetch bytes), 2 (execute), 3 (store write), 4 (halted).
    function automatic ctl_t model(int step, logic [15:0] ir, logic [3:0] fl);
        ctl_t c = idleCtl();
        int op = int'(ir[15:10]);
        c.seqState = 3'(step);
        if (step < 2) begin
            c.memCs = 1'b0;
            c.irWrite = 1'b1;
            c.irLh = (step == 1);
            c.arfReg = 3'b100;
            c.arfFun = 3'b001;
        end else if (step == 2) begin
            if (op == 0 || (op == 1 && fl[3] == 1'b0)) begin
                c.muxB = 2'd3; c.arfReg = 3'b100; c.arfFun = 3'b010;
            end else if (op == 2) begin
                c.muxA = 2'd3; c.rfFun = 3'b010; c.regSel = 4'b1000 >> ir[9:8];
            end else if (op == 3) begin
                c.outA = 3'(ir[3:2]); c.outB = 3'(ir[1:0]); c.aluFun = 5'b10100; c.aluWf = ir[9];
                c.rfFun = 3'b010; c.regSel = 4'b1000 >> ir[5:4];
            end else if (op == 4) begin
                c.rfFun = 3'b001; c.regSel = 4'b1000 >> ir[5:4];
            end else if (op == 5) begin
                c.muxB = 2'd3; c.arfReg = 3'b010; c.arfFun = 3'b010;
            end
        end else if (step == 3) begin
            c.outA = 3'(ir[9:8]); c.aluFun = 5'b10000; c.outD = 2'd2; c.memCs = 1'b0; c.memWr = 1'b1;
        end else begin
            c.halted = 1'b1;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic toExec(input logic [15:0] ir);
        bus.IROut = 16'($urandom);
        tick();
        bus.IROut = 16'($urandom);
        tick();
        bus.IROut = ir;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.IROut = 16'($urandom);
        bus.FlagsOut = 4'($urandom);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            nChecks++;
            if (act !== idleCtl()) begin nFail++; $display("FAIL reset_idle%0d: got %h expected %h", i, act, idleCtl()); end
            tick();
        end
        Reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s == 2) bus.IROut = 16'h1000;
            @(negedge Clock);
            exp = model(s, bus.IROut, bus.FlagsOut);
            nChecks++;
            if (act !== exp) begin nFail++; $display("FAIL reset_seq%0d: got %h expected %h", s, act, exp); end
            tick();
        end
    endtask

    task automatic test_movl();
        doReset();
        toExec(16'h0A5C);
        @(negedge Clock);
        exp = idleCtl(); exp.seqState = 3'd2; exp.muxA = 2'd3; exp.rfFun = 3'b010; exp.regSel = 4'b0010;
        nChecks++;
        if (act !== exp) begin nFail++; $display("FAIL movl_exec: got %h expected %h", act, exp); end
        tick();
        @(negedge Clock);
        nChecks++;
        if (act.seqState !== 3'd0) begin nFail++; $display("FAIL movl_next: got %0d expected 0", act.seqState); end
    endtask

    task automatic test_add();
        doReset();
        toExec(16'h0E1B);
        @(negedge Clock);
        exp = idleCtl(); exp.seqState = 3'd2; exp.outA = 3'd2; exp.outB = 3'd3; exp.aluFun = 5'b10100;
        exp.aluWf = 1'b1; exp.rfFun = 3'b010; exp.regSel = 4'b0100;
        nChecks++;
        if (act !== exp) begin nFail++; $display("FAIL add_exec: got %h expected %h", act, exp); end
    endtask

    task automatic test_bne();
        for (int z = 1; z >= 0; z--) begin
            doReset();
            bus.FlagsOut = (z == 1) ? 4'b1000 : 4'b0000;
            toExec(16'h0440);
            @(negedge Clock);
            exp = idleCtl(); exp.seqState = 3'd2;
            if (z == 0) begin exp.muxB = 2'd3; exp.arfReg = 3'b100; exp.arfFun = 3'b010; end
            nChecks++;
            if (act !== exp) begin nFail++; $display("FAIL bne_z%0d: got %h expected %h", z, act, exp); end
        end
    endtask

    task automatic test_st();
        doReset();
        toExec(16'h1510);
        @(negedge Clock);
        exp = idleCtl(); exp.seqState = 3'd2; exp.muxB = 2'd3; exp.arfReg = 3'b010; exp.arfFun = 3'b010;
        nChecks++;
        if (act !== exp) begin nFail++; $display("FAIL st_exec: got %h expected %h", act, exp); end
        tick();
        @(negedge Clock);
        exp = idleCtl(); exp.seqState = 3'd3; exp.outA = 3'd1; exp.aluFun = 5'b10000; exp.outD = 2'd2;
        exp.memCs = 1'b0; exp.memWr = 1'b1;
        nChecks++;
        if (act !== exp) begin nFail++; $display("FAIL st_exec2: got %h expected %h", act, exp); end
        tick();
        @(negedge Clock);
        nChecks++;
        if (act.seqState !== 3'd0) begin nFail++; $display("FAIL st_next: got %0d expected 0", act.seqState); end
    endtask

    task automatic test_halt();
        doReset();
        toExec(16'hFC00);
        @(negedge Clock);
        exp = idleCtl(); exp.seqState = 3'd2;
        nChecks++;
        if (act !== exp) begin nFail++; $display("FAIL halt_exec: got %h expected %h", act, exp); end
        exp = idleCtl(); exp.seqState = 3'd4; exp.halted = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.IROut = 16'($urandom);
            bus.FlagsOut = 4'($urandom);
            @(negedge Clock);
            nChecks++;
            if (act !== exp) begin nFail++; $display("FAIL halt_hold%0d: got %h expected %h", i, act, exp); end
        end
        tick();
        doReset();
        @(negedge Clock);
        exp = model(0, bus.IROut, bus.FlagsOut);
        nChecks++;
        if (act !== exp) begin nFail++; $display("FAIL halt_exit: got %h expected %h", act, exp); end
        tick();
    endtask

    task automatic test_reset_exec2();
        doReset();
        toExec(16'h1510);
        tick();
        Reset = 1'b1;
        @(negedge Clock);
        nChecks++;
        if (act !== idleCtl()) begin nFail++; $display("FAIL rst_exec2_during: got %h expected %h", act, idleCtl()); end
        tick();
        @(negedge Clock);
        nChecks++;
        if (act !== idleCtl()) begin nFail++; $display("FAIL rst_exec2_after: got %h expected %h", act, idleCtl()); end
        Reset = 1'b0;
        #1;
        exp = model(0, bus.IROut, bus.FlagsOut);
        nChecks++;
        if (act !== exp) begin nFail++; $display("FAIL rst_exec2_release: got %h expected %h", act, exp); end
        tick();
    endtask

`ifdef CU_ILLEGAL_TRAP_EN
    task automatic test_illegal();
        doReset();
        toExec(16'h2000);
        @(negedge Clock);
        nChecks++;
        if (bus.Illegal !== 1'b0) begin nFail++; $display("FAIL illegal_pre: got %b expected 0", bus.Illegal); end
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.IROut = 16'($urandom);
            @(negedge Clock);
            nChecks++;
            if (bus.Illegal !== 1'b1 || act.seqState !== 3'd4) begin
                nFail++; $display("FAIL illegal_hold%0d: got ill=%b st=%0d expected ill=1 st=4", i, bus.Illegal, act.seqState);
            end
        end
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        @(negedge Clock);
        nChecks++;
        if (bus.Illegal !== 1'b0) begin nFail++; $display("FAIL illegal_clear: got %b expected 0", bus.Illegal); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [15:0] ir;
        int op, steps;
        doReset();
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 7);
`ifdef CU_ILLEGAL_TRAP_EN
            if (op > 5) op = $urandom_range(0, 5);
`else
            if (op > 5) op = $urandom_range(6, 62);
`endif
            ir = {6'(op), 10'($urandom_range(0, 1023))};
            steps = (op == 5) ? 4 : 3;
            for (int s = 0; s < steps; s++) begin
                bus.IROut = (s < 2) ? 16'($urandom) : ir;
                bus.FlagsOut = 4'($urandom);
                @(negedge Clock);
                exp = model(s, ir, bus.FlagsOut);
                nChecks++;
                if (act !== exp) begin
                    nFail++; $display("FAIL rand_i%0d_s%0d ir=%h: got %h expected %h", n, s, ir, act, exp);
                end
                tick();
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        bus.IROut = '0;
        bus.FlagsOut = '0;
        test_reset();
        test_movl();
        test_add();
        test_bne();
        test_st();
        test_halt();
        test_reset_exec2();
`ifdef CU_ILLEGAL_TRAP_EN
        test_illegal();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired multi-cycle control unit sitting directly upstream of the ALU datapath system; drives every datapath control input.
- Fetches a 16-bit instruction as two bytes through the IR, decodes IROut, sequences execute cycles and samples ALU flags for conditional branches.
- One clock; reset is synchronous and active-high, ports Clock and Reset.

Parameters:
- RF_FS_LOAD, 3'b010, RF/ARF FunSel code for load from I
- RF_FS_INC, 3'b001, RF/ARF FunSel code for increment
- ALU_PASSA, 5'b10000, ALU FunSel code: ALUOut = A (16-bit)
- ALU_ADD, 5'b10100, ALU FunSel code: ALUOut = A + B (16-bit)

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- IROut  in  16  instruction register contents
- FlagsOut  in  4  ALU flags; bit3 = Z
- RF_OutASel, RF_OutBSel, RF_FunSel  out  3 each  register file controls; OutSel 0..3 = R1..R4
- RF_RegSel, RF_ScrSel  out  4 each  one-hot write enables; RegSel bit3 = R1 .. bit0 = R4
- ALU_FunSel  out  5;  ALU_WF  out  1
- ARF_OutCSel, ARF_OutDSel  out  2 each  address register file selects; 0 = PC, 2 = AR
- ARF_FunSel  out  3;  ARF_RegSel  out  3  one-hot; bit2 = PC, bit1 = AR, bit0 = SP
- IR_LH, IR_Write, Mem_WR, Mem_CS  out  1 each  Mem_CS active-low; Mem_WR 1 = write
- MuxASel, MuxBSel  out  2 each;  MuxCSel  out  1
- SeqState  out  3  current state code
- Halted  out  1  high in HALT

Behaviour:
- States: FETCH_L = 0, FETCH_H = 1, EXEC = 2, EXEC2 = 3, HALT = 4.
- Outputs are combinational from the state register and IROut.
- Idle values, driven in every cycle unless listed otherwise:
  - all RegSel/ScrSel/ARF_RegSel = 0
  - ALU_WF = 0, IR_Write = 0, Mem_WR = 0, Mem_CS = 1
  - muxes, FunSels and OutSels = 0
- Reset: state <- FETCH_L next edge. While Reset is high, all outputs are idle and Halted = 0. Reset overrides any state, including HALT and EXEC2.
- FETCH_L: ARF_OutDSel = 0, Mem_CS = 0, IR_Write = 1, IR_LH = 0, ARF_RegSel = 3'b100, ARF_FunSel = RF_FS_INC. Next state FETCH_H.
- FETCH_H: same as FETCH_L but IR_LH = 1. Next state EXEC. PC has advanced by 2 when EXEC starts.
- Decode in EXEC: opcode = IROut[15:10].
  - 0x00 BRA: MuxBSel = 3, ARF_RegSel = 3'b100, ARF_FunSel = RF_FS_LOAD, so PC <- {8'b0, IR[7:0]}.
  - 0x01 BNE: as BRA only if FlagsOut[3] == 0; otherwise idle.
  - 0x02 MOVL: MuxASel = 3, RF_FunSel = RF_FS_LOAD, RegSel bit for R(IR[9:8]).
  - 0x03 ADD: OutASel = IR[3:2], OutBSel = IR[1:0], ALU_FunSel = ALU_ADD, ALU_WF = IR[9], MuxASel = 0, load R(IR[5:4]).
  - 0x04 INC: RF_FunSel = RF_FS_INC, RegSel bit for R(IR[5:4]).
  - 0x05 ST: MuxBSel = 3, load AR. Next state EXEC2.
  - 0x3F HALT: next state HALT.
  - Every other opcode: NOP.
- Next state after EXEC is FETCH_L, except for ST and HALT.
- EXEC2 (ST only): OutASel = IR[9:8], ALU_FunSel = ALU_PASSA, MuxCSel = 0, ARF_OutDSel = 2, Mem_CS = 0, Mem_WR = 1. Next state FETCH_L.
- HALT: idle outputs, Halted = 1, stays until Reset.
- Latencies: 3 cycles for BRA, BNE, MOVL, ADD, INC, NOP; 4 cycles for ST.
- Flag timing: BNE samples FlagsOut in the EXEC cycle, so it sees flags written by any earlier instruction's EXEC edge.
- Register index in IR fields: 0..3 map to R1..R4.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- When defined: an undefined opcode in EXEC goes to HALT, and output port Illegal (1 bit) is set and held until Reset.
- When undefined: there is no Illegal port, and undefined opcodes execute as NOP.

Test Plan:
- Reset high 2 cycles, then low -> SeqState 0, 1, 2 on successive cycles; Mem_CS = 0 and IR_Write = 1 in states 0 and 1; IR_LH = 0 then 1; ARF_RegSel = 3'b100 and ARF_FunSel = 3'b001 in both.
- IROut = 16'h0A5C (MOVL R3, 0x5C) in EXEC -> MuxASel = 3, RF_FunSel = 3'b010, RF_RegSel = 4'b0010; next state 0.
- IROut = 16'h0E1B (ADD S=1, Rd=R2, Rs1=R3, Rs2=R4) -> OutASel = 2, OutBSel = 3, ALU_FunSel = 5'b10100, ALU_WF = 1, RF_RegSel = 4'b0100.
- IROut = 16'h0440 (BNE 0x40) with FlagsOut = 4'b1000 -> ARF_RegSel = 0; with FlagsOut = 4'b0000 -> MuxBSel = 3, ARF_RegSel = 3'b100, ARF_FunSel = 3'b010.
- IROut = 16'h1510 (ST R2 -> [0x10]) -> EXEC loads AR; EXEC2: Mem_WR = 1, Mem_CS = 0, ARF_OutDSel = 2, OutASel = 1; back to state 0.
- IROut = 16'hFC00 -> Halted = 1 held 10 cycles. Reset asserted mid-EXEC2 -> next cycle SeqState = 0 with idle outputs. With CU_ILLEGAL_TRAP_EN, IROut = 16'h2000 -> Illegal = 1, SeqState = 4.
